scr1_clk_gate_ctrl: RTL

Core clock-gating controller. It decides when the core clock may be stopped and drives the enable into the core clock-gate cell, which sits directly downstream. It runs on the free-running clock, enters sleep on a WFI-style request once the pipeline has been idle long enough, and restores the clock on interrupt or debug wake events. It holds the core for a fixed settle window before releasing it.

---
 rtl/scr1_clk_ctrl_pkg.sv | 16 +
 rtl/scr1_clk_gate_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/scr1_clk_ctrl_pkg.sv
// Shared types and default timing constants for the core clock-gating controller.
// The state encoding keeps RUN at zero so a cleared register means "clock running".
package scr1_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_SLEEP     = 2'd2,
        ST_WAKE      = 2'd3
    } clk_state_e;

    localparam int unsigned IDLE_HYST_DEF = 4;
    localparam int unsigned WAKE_DLY_DEF  = 2;
    localparam int unsigned CNT_W_DEF     = 4;

endpackage

// File: rtl/scr1_clk_gate_ctrl.sv
// Core clock-gating controller: gates the core clock after a sleep request plus an idle
// hysteresis window, and restores it on interrupt/debug wake with a hold-off settle window.
module scr1_clk_gate_ctrl
    import scr1_clk_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_HYST = IDLE_HYST_DEF,
    parameter int unsigned WAKE_DLY  = WAKE_DLY_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sleep_req,
    input  logic pipe_idle,
    input  logic wake_evt,
    input  logic dbg_req,
    output logic clk_en,
    output logic core_hold,
    output logic sleep_status,
    output logic wake_ack
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_HYST - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_DLY - 1);

    clk_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             wake;

    // Wake is decoded straight from the inputs so it still works while the core is gated.
    assign wake = wake_evt | dbg_req;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (sleep_req && !wake) begin
                    state_nxt = ST_WAIT_IDLE;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_IDLE: begin
                if (wake || !sleep_req) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else if (!pipe_idle) begin
                    cnt_nxt = '0;
                end else if (cnt == IDLE_LAST) begin
                    state_nxt = ST_SLEEP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_SLEEP: begin
                // sleep_req is frozen by the gated core here, so only wake matters.
                if (wake) begin
                    state_nxt = ST_WAKE;
                    cnt_nxt   = '0;
                end
            end
            ST_WAKE: begin
                if (cnt == WAKE_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so clk_en only moves on a clk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            cnt          <= '0;
            clk_en       <= 1'b1;
            core_hold    <= 1'b0;
            sleep_status <= 1'b0;
            wake_ack     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values together.
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            clk_en       <= (state_nxt != ST_SLEEP);
            core_hold    <= (state_nxt == ST_WAKE);
            sleep_status <= (state_nxt == ST_SLEEP);
            wake_ack     <= (state == ST_WAKE) && (state_nxt == ST_RUN);
        end
    end

    a_sleep_gated: assert property (@(posedge clk) disable iff (!rst_n) sleep_status |-> !clk_en);
    a_hold_clocked: assert property (@(posedge clk) disable iff (!rst_n) core_hold |-> clk_en);
    a_ack_pulse: assert property (@(posedge clk) disable iff (!rst_n) wake_ack |=> !wake_ack);

endmodule
